// File: rtl/imm_extend_pipe.sv
// Two-stage immediate extractor/extender with valid/ready handshakes and a saturating illegal-request counter.
// Optional feature: define IMM_BRANCH_SHIFT_EN to scale B/CB offsets by 4 (word-to-byte).
module imm_extend_pipe #(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 8
) (
    input  logic              CLK,
    input  logic              Reset_L,
    input  logic              InValid,
    output logic              InReady,
    input  logic [31:0]       Instr,
    input  logic [2:0]        ImmType,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [DATA_W-1:0] BusImm,
    output logic              Illegal,
    output logic [CNT_W-1:0]  IllegalCnt
);

    typedef enum logic [2:0] {
        IMM_I  = 3'd0,
        IMM_D  = 3'd1,
        IMM_B  = 3'd2,
        IMM_CB = 3'd3,
        IMM_IW = 3'd4
    } imm_type_e;

`ifdef IMM_BRANCH_SHIFT_EN
    localparam int BR_SHIFT = 2;
`else
    localparam int BR_SHIFT = 0;
`endif

    logic              s1_valid;
    logic [31:0]       s1_instr;
    logic [2:0]        s1_type;
    logic              s2_ready;
    logic [DATA_W-1:0] dec_imm;
    logic              dec_illegal;
    logic [1:0]        iw_hw;
    logic              s1_unused;

    // A stage may load when it is empty or its content leaves on this edge.
    assign s2_ready  = !OutValid || OutReady;
    assign InReady   = !s1_valid || s2_ready;
    assign iw_hw     = s1_instr[22:21];
    // No format uses the top opcode bits.
    assign s1_unused = ^s1_instr[31:26];

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            s1_valid <= 1'b0;
        end else if (InReady) begin
            s1_valid <= InValid;
        end
    end

    // NOTE: payload registers carry no reset; s1_valid qualifies them, so stale contents are never used.
    always_ff @(posedge CLK) begin
        if (InReady && InValid) begin
            s1_instr <= Instr;
            s1_type  <= ImmType;
        end
    end

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        dec_imm     = '0;
        dec_illegal = 1'b0;
        case (s1_type)
            IMM_I:  dec_imm = {{(DATA_W-12){s1_instr[21]}}, s1_instr[21:10]};
            IMM_D:  dec_imm = {{(DATA_W-9){s1_instr[20]}}, s1_instr[20:12]};
            IMM_B:  dec_imm = {{(DATA_W-26){s1_instr[25]}}, s1_instr[25:0]} << BR_SHIFT;
            IMM_CB: dec_imm = {{(DATA_W-19){s1_instr[23]}}, s1_instr[23:5]} << BR_SHIFT;
            IMM_IW: begin
                // A halfword slot that does not fit inside DATA_W is rejected.
                if ((int'(iw_hw) + 1) * 16 > DATA_W) begin
                    dec_illegal = 1'b1;
                end else begin
                    dec_imm = DATA_W'(s1_instr[20:5]) << {iw_hw, 4'b0000};
                end
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            OutValid   <= 1'b0;
            BusImm     <= '0;
            Illegal    <= 1'b0;
            IllegalCnt <= '0;
        end else if (s2_ready) begin
            OutValid <= s1_valid;
            if (s1_valid) begin
                BusImm  <= dec_imm;
                Illegal <= dec_illegal;
                if (dec_illegal && (IllegalCnt != '1)) begin
                    IllegalCnt <= IllegalCnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench for imm_extend_pipe: directed formats, stall/backpressure, reset flush,
// counter saturation and randomized traffic against a behavioural model.
module tb_imm_extend_pipe;

    logic        clk = 1'b0;
    logic        reset_l = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instr = '0;
    logic [2:0]  imm_type = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] bus_imm;
    logic        illegal;
    logic [7:0]  illegal_cnt;

    logic        in_ready32;
    logic        out_valid32;
    logic [31:0] bus_imm32;
    logic        illegal32;
    logic [7:0]  illegal_cnt32;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imm_extend_pipe #(.DATA_W(64), .CNT_W(8)) dut (
        .CLK(clk), .Reset_L(reset_l), .InValid(in_valid), .InReady(in_ready),
        .Instr(instr), .ImmType(imm_type), .OutValid(out_valid), .OutReady(out_ready),
        .BusImm(bus_imm), .Illegal(illegal), .IllegalCnt(illegal_cnt)
    );

    imm_extend_pipe #(.DATA_W(32), .CNT_W(8)) dut32 (
        .CLK(clk), .Reset_L(reset_l), .InValid(in_valid), .InReady(in_ready32),
        .Instr(instr), .ImmType(imm_type), .OutValid(out_valid32), .OutReady(out_ready),
        .BusImm(bus_imm32), .Illegal(illegal32), .IllegalCnt(illegal_cnt32)
    );

    // Reference: {illegal, immediate} computed from the format rules with plain arithmetic.
    function automatic logic [64:0] ref_imm(input logic [31:0] ins, input logic [2:0] t, input int dw);
        longint v;
        int     hw;
        int     scale;
`ifdef IMM_BRANCH_SHIFT_EN
        scale = 4;
`else
        scale = 1;
`endif
        v = 0;
        case (t)
            3'd0: v = longint'($signed(ins[21:10]));
            3'd1: v = longint'($signed(ins[20:12]));
            3'd2: v = longint'($signed(ins[25:0])) * scale;
            3'd3: v = longint'($signed(ins[23:5])) * scale;
            3'd4: begin
                hw = int'(ins[22:21]);
                if (16 * hw + 16 > dw) return {1'b1, 64'd0};
                v = longint'({48'd0, ins[20:5]}) << (16 * hw);
            end
            default: return {1'b1, 64'd0};
        endcase
        if (dw == 32) v = longint'({32'd0, v[31:0]});
        return {1'b0, v};
    endfunction

    task automatic do_reset();
        reset_l   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        instr     = '0;
        imm_type  = '0;
        repeat (2) @(negedge clk);
        reset_l = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (out_valid !== 1'b0 || bus_imm !== 64'd0 || illegal !== 1'b0 || illegal_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_state: out_valid=%b bus_imm=%h illegal=%b cnt=%h, required 0/0/0/0",
                     out_valid, bus_imm, illegal, illegal_cnt);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b required 1", in_ready);
        end
        do_reset();
    endtask

    task automatic test_formats();
        logic [31:0] t_instr [6] = '{32'h003FFC00, 32'h00100000, 32'h00000001,
                                     32'h00800000, 32'h005579A0, 32'h00624680};
        logic [2:0]  t_type  [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
        logic [63:0] t_exp   [6];
        t_exp[0] = 64'hFFFFFFFF_FFFFFFFF;
        t_exp[1] = 64'hFFFFFFFF_FFFFFF00;
`ifdef IMM_BRANCH_SHIFT_EN
        t_exp[2] = 64'h4;
        t_exp[3] = 64'hFFFFFFFF_FFF00000;
`else
        t_exp[2] = 64'h1;
        t_exp[3] = 64'hFFFFFFFF_FFFC0000;
`endif
        t_exp[4] = 64'h0000ABCD_00000000;
        t_exp[5] = 64'h1234_0000_0000_0000;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            in_valid  = 1'b1;
            instr     = t_instr[i];
            imm_type  = t_type[i];
            out_ready = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL fmt%0d_early: out_valid=%b one cycle after accept, required 0", i, out_valid);
            end
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || bus_imm !== t_exp[i] || illegal !== 1'b0) begin
                errors++;
                $display("FAIL fmt%0d_result: valid=%b imm=%h illegal=%b, required 1/%h/0",
                         i, out_valid, bus_imm, illegal, t_exp[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_iw_width32();
        do_reset();
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        instr     = 32'h005579A0;
        imm_type  = 3'd4;
        @(negedge clk);
        instr = 32'h0037DDE0;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid32 !== 1'b1 || illegal32 !== 1'b1 || bus_imm32 !== 32'd0 || illegal_cnt32 !== 8'd1) begin
            errors++;
            $display("FAIL iw32_illegal: valid=%b illegal=%b imm=%h cnt=%0d, required 1/1/0/1",
                     out_valid32, illegal32, bus_imm32, illegal_cnt32);
        end
        checks++;
        if (illegal !== 1'b0 || bus_imm !== 64'h0000ABCD_00000000 || illegal_cnt !== 8'd0) begin
            errors++;
            $display("FAIL iw64_legal: illegal=%b imm=%h cnt=%0d, required 0/0000abcd00000000/0",
                     illegal, bus_imm, illegal_cnt);
        end
        @(negedge clk);
        checks++;
        if (out_valid32 !== 1'b1 || illegal32 !== 1'b0 || bus_imm32 !== 32'hBEEF0000 || illegal_cnt32 !== 8'd1) begin
            errors++;
            $display("FAIL iw32_hw1: valid=%b illegal=%b imm=%h cnt=%0d, required 1/0/beef0000/1",
                     out_valid32, illegal32, bus_imm32, illegal_cnt32);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [31:0] req_instr [4];
        logic [2:0]  req_type  [4];
        logic [64:0] exp_q [$];
        logic [64:0] held;
        logic [64:0] got;
        int sent = 0, recv = 0, stall = 0;
        bit have_held = 0;
        bit acc, pop;
        for (int i = 0; i < 4; i++) begin
            req_instr[i] = $urandom;
            req_type[i]  = 3'($urandom_range(0, 4));
        end
        for (int cyc = 0; cyc < 60 && recv < 4; cyc++) begin
            @(negedge clk);
            in_valid  = (sent < 4);
            instr     = (sent < 4) ? req_instr[sent] : 32'd0;
            imm_type  = (sent < 4) ? req_type[sent] : 3'd0;
            out_ready = (stall >= 3);
            #1;
            got = {illegal, bus_imm};
            if (out_valid && !out_ready) begin
                if (have_held) begin
                    checks++;
                    if (got !== held) begin
                        errors++;
                        $display("FAIL b2b_stable: result changed to %h while stalled, required %h", got, held);
                    end
                end
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_in_ready: got %b with both stages full, required 0", in_ready);
                end
                held      = got;
                have_held = 1;
                stall++;
            end
            acc = in_valid && in_ready;
            pop = out_valid && out_ready;
            if (pop) begin
                checks++;
                if (exp_q.size() == 0 || got !== exp_q[0]) begin
                    errors++;
                    $display("FAIL b2b_order%0d: got %h required %h", recv, got,
                             exp_q.size() ? exp_q[0] : 65'd0);
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                recv++;
            end
            if (acc) begin
                exp_q.push_back(ref_imm(instr, imm_type, 64));
                sent++;
            end
        end
        checks++;
        if (recv != 4 || stall < 3) begin
            errors++;
            $display("FAIL b2b_count: received %0d after %0d stall cycles, required 4 after 3", recv, stall);
        end
    endtask

    task automatic test_reset_flush();
        bit saw_valid = 0;
        bit done = 0;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        imm_type  = 3'd7;
        instr     = $urandom;
        @(negedge clk);
        instr = $urandom;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || illegal_cnt === 8'd0) begin
            errors++;
            $display("FAIL flush_setup: out_valid=%b cnt=%0d, required 1 and nonzero", out_valid, illegal_cnt);
        end
        #2 reset_l = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || illegal_cnt !== 8'd0 || illegal !== 1'b0 || bus_imm !== 64'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_async: valid=%b cnt=%0d illegal=%b imm=%h in_ready=%b, required 0/0/0/0/1",
                     out_valid, illegal_cnt, illegal, bus_imm, in_ready);
        end
        in_valid = 1'b1;
        imm_type = 3'd0;
        instr    = 32'h00000400;
        @(negedge clk);
        in_valid  = 1'b0;
        reset_l   = 1'b1;
        out_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (out_valid) saw_valid = 1;
        end
        checks++;
        if (saw_valid) begin
            errors++;
            $display("FAIL flush_stale: out_valid seen after release with nothing accepted, required none");
        end
        in_valid = 1'b1;
        instr    = 32'h00001C00;
        imm_type = 3'd0;
        @(negedge clk);
        in_valid = 1'b0;
        for (int cyc = 0; cyc < 6 && !done; cyc++) begin
            if (out_valid) begin
                done = 1;
                checks++;
                if (bus_imm !== 64'd7 || illegal !== 1'b0) begin
                    errors++;
                    $display("FAIL flush_first: imm=%h illegal=%b, required 7/0", bus_imm, illegal);
                end
            end else begin
                @(negedge clk);
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL flush_timeout: no result within 6 cycles, required one");
        end
        @(negedge clk);
    endtask

    task automatic test_saturation();
        int sent = 0, recv = 0, bad_res = 0, bad_cnt = 0, exp_cnt;
        do_reset();
        for (int cyc = 0; cyc < 400 && recv < 300; cyc++) begin
            @(negedge clk);
            in_valid  = (sent < 300);
            imm_type  = 3'd7;
            instr     = $urandom;
            out_ready = 1'b1;
            #1;
            exp_cnt = recv + (out_valid ? 1 : 0);
            if (exp_cnt > 255) exp_cnt = 255;
            if (illegal_cnt !== 8'(exp_cnt)) begin
                if (bad_cnt == 0) $display("FAIL sat_track: cnt=%0d required %0d", illegal_cnt, exp_cnt);
                bad_cnt++;
            end
            if (out_valid && out_ready) begin
                if (illegal !== 1'b1 || bus_imm !== 64'd0) bad_res++;
                recv++;
            end
            if (in_valid && in_ready) sent++;
        end
        in_valid = 1'b0;
        checks++;
        if (bad_cnt != 0) errors++;
        checks++;
        if (recv != 300 || bad_res != 0) begin
            errors++;
            $display("FAIL sat_results: received %0d with %0d bad, required 300 with 0", recv, bad_res);
        end
        @(negedge clk);
        checks++;
        if (illegal_cnt !== 8'hFF) begin
            errors++;
            $display("FAIL sat_final: cnt=%h required ff", illegal_cnt);
        end
    endtask

    task automatic test_random();
        logic [64:0] exp_q [$];
        logic [64:0] got;
        int ill_acc = 0, exp_cnt, recv = 0;
        do_reset();
        for (int cyc = 0; cyc < 400 || exp_q.size() != 0; cyc++) begin
            if (cyc >= 440) break;
            @(negedge clk);
            in_valid  = (cyc < 400) && ($urandom_range(0, 3) != 0);
            instr     = $urandom;
            imm_type  = 3'($urandom_range(0, 7));
            out_ready = (cyc >= 400) || ($urandom_range(0, 3) != 0);
            #1;
            if (out_valid && out_ready) begin
                got = {illegal, bus_imm};
                checks++;
                if (exp_q.size() == 0 || got !== exp_q[0]) begin
                    errors++;
                    $display("FAIL rand%0d: got %h required %h", recv, got,
                             exp_q.size() ? exp_q[0] : 65'd0);
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                recv++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_imm(instr, imm_type, 64));
                if (ref_imm(instr, imm_type, 64) >> 64) ill_acc++;
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
        exp_cnt = (ill_acc > 255) ? 255 : ill_acc;
        checks++;
        if (exp_q.size() != 0 || out_valid !== 1'b0 || illegal_cnt !== 8'(exp_cnt)) begin
            errors++;
            $display("FAIL rand_drain: %0d pending valid=%b cnt=%0d, required 0 pending, 0, cnt %0d",
                     exp_q.size(), out_valid, illegal_cnt, exp_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_formats();
        test_iw_width32();
        test_back_to_back();
        test_reset_flush();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imm_extend_pipe.md
IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

Interface
REQ-001 Parameter DATA_W, default 64, is the output immediate width; legal values are 32 or 64.
REQ-002 Parameter CNT_W, default 8, is the width of the illegal-request counter.
REQ-003 CLK  input  1  is the single clock; every register samples on its rising edge.
REQ-004 Reset_L  input  1  is the reset: asynchronous and active-low.
REQ-005 InValid  input  1  signals that a request (Instr, ImmType) is offered.
REQ-006 InReady  output  1  signals that the block accepts the request this cycle.
REQ-007 Instr  input  32  is the instruction word.
REQ-008 ImmType  input  3  selects the format: 0 I (imm12 [21:10]), 1 D (imm9 [20:12]), 2 B (imm26 [25:0]), 3 CB (imm19 [23:5]), 4 IW (imm16 [20:5], hw [22:21]); 5-7 are illegal.
REQ-009 OutValid  output  1  signals that BusImm/Illegal hold a result.
REQ-010 OutReady  input  1  signals that the consumer takes the result this cycle.
REQ-011 BusImm  output  DATA_W  is the extended immediate.
REQ-012 Illegal  output  1  flags that the result came from an illegal request.
REQ-013 IllegalCnt  output  CNT_W  counts illegal requests, saturating.

Function
REQ-014 The block SHALL be a two-stage pipeline.
- Stage 1 registers Instr and ImmType.
- Stage 2 registers BusImm and Illegal.
- Latency is 2 cycles from the accepting edge to OutValid when not stalled.
REQ-015 Transfers SHALL occur as follows.
- A request transfers on any edge with InValid&InReady high.
- A result transfers on any edge with OutValid&OutReady high.
REQ-016 Ready SHALL be combinational: s2_ready = !OutValid | OutReady, and InReady = !s1_valid | s2_ready.
- Full throughput: one result per cycle with OutReady held high.
REQ-017 While OutValid=1 and OutReady=0, BusImm, Illegal and OutValid SHALL hold stable, and stage 1 SHALL hold when full.
REQ-018 Types I, D, B and CB SHALL sign-extend their field to DATA_W from its MSB.
REQ-019 Type IW SHALL zero-extend imm16 and shift it left by 16*hw.
- If 16*hw+16 > DATA_W, the request is illegal.
REQ-020 An illegal request SHALL still flow through the pipeline with BusImm=0 and Illegal=1.
- IllegalCnt increments by 1 on the edge where stage 2 loads that result.
- IllegalCnt saturates at all-ones.
REQ-021 A new request may enter on the same edge that a result leaves; no bubble SHALL be inserted.
REQ-022 The pipeline SHALL neither drop nor duplicate results; results emerge in acceptance order.

Reset
REQ-023 On Reset_L=0, the block SHALL clear the following immediately, regardless of CLK:
- s1_valid=0, OutValid=0, BusImm=0, Illegal=0, IllegalCnt=0.
REQ-024 While in reset, InReady SHALL read 1; a request offered while Reset_L=0 is not accepted.
REQ-025 Assertion of Reset_L mid-operation SHALL discard all in-flight requests.
- After release, the first accepted request produces the first result.

Configuration
REQ-026 Macro IMM_BRANCH_SHIFT_EN controls branch-offset scaling.
- Defined: B and CB results are shifted left by 2 after sign extension (word-to-byte offset); bits shifted beyond DATA_W are discarded.
- Undefined: B and CB results are the unscaled sign-extended fields.
- Types I, D and IW are unaffected either way.

Verification
REQ-027 The bench SHALL cover the following directed scenarios (DATA_W=64 unless stated):
- I, Instr=32'h003FFC00 -> 2 cycles later BusImm=64'hFFFFFFFF_FFFFFFFF, Illegal=0.
- D, Instr=32'h00100000 -> BusImm=64'hFFFFFFFF_FFFFFF00.
- B, Instr=32'h00000001 -> BusImm=64'h4 with IMM_BRANCH_SHIFT_EN, 64'h1 without it.
- IW, Instr=32'h005579A0 -> BusImm=64'h0000ABCD_00000000. With DATA_W=32 the same request gives Illegal=1, BusImm=0, IllegalCnt=1.
- Four back-to-back requests with OutReady held 0 for 3 cycles -> InReady falls once both stages are full; BusImm is stable while stalled; all 4 results arrive in order.
- Reset_L pulsed low with 2 requests in flight -> OutValid=0 and IllegalCnt=0 immediately; no stale result after release.
- 300 ImmType=7 requests with CNT_W=8 -> IllegalCnt saturates at 8'hFF.
